// File: rtl/jpeg_output_y_writer_pkg.sv
// Shared definitions for the JPEG Y output writer: FSM encoding,
// block geometry and pixel clamp bounds.
package jpeg_output_y_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_SPACE = 2'd1,
    ST_WRITE      = 2'd2
  } writer_state_e;

  localparam int BLOCK_SIZE = 64;
  localparam int PIXEL_MIN  = 0;
  localparam int PIXEL_MAX  = 255;

endpackage

// File: rtl/jpeg_output_y_writer_clamp.sv
// Level shift and saturate one signed IDCT sample into an 8-bit pixel.
module jpeg_output_clamp
  import jpeg_output_y_writer_pkg::*;
#(
  parameter int LEVEL_SHIFT = 128
) (
  input  logic [15:0] sample,
  output logic [7:0]  pixel
);

  localparam logic signed [16:0] SHIFT  = 17'(LEVEL_SHIFT);
  localparam logic signed [16:0] LO_LIM = 17'(PIXEL_MIN);
  localparam logic signed [16:0] HI_LIM = 17'(PIXEL_MAX);

  logic signed [16:0] shifted;

  // 17 bits holds any 16-bit sample plus the shift without wrapping
  assign shifted = $signed({sample[15], sample}) + SHIFT;

  always_comb begin
    pixel = shifted[7:0];
    if (shifted < LO_LIM) begin
      pixel = 8'(PIXEL_MIN);
    end else if (shifted > HI_LIM) begin
      pixel = 8'(PIXEL_MAX);
    end
  end

endmodule

// File: rtl/jpeg_output_y_writer.sv
// Writes level-shifted, clamped Y samples of 8x8 blocks into the output
// Y buffer, transposing column-major input into raster order.
module jpeg_output_y_writer
  import jpeg_output_y_writer_pkg::*;
#(
  parameter int RAM_DEPTH   = 512,
  parameter int LEVEL_SHIFT = 128
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        inport_valid_i,
  input  logic [15:0] inport_data_i,
  output logic        inport_accept_o,
  input  logic [31:0] ram_level_i,
  output logic        outport_push_o,
  output logic [5:0]  outport_idx_o,
  output logic [31:0] outport_data_o,
  output logic        block_done_o,
  output logic        busy_o
);

  localparam logic [31:0] SPACE_LIMIT = 32'(RAM_DEPTH - BLOCK_SIZE);
  localparam logic [5:0]  LAST_SAMPLE = 6'(BLOCK_SIZE - 1);

  writer_state_e state;
  logic [5:0]    cnt;
  logic [7:0]    pixel;
  logic          space_ok;
  logic          accept;

  jpeg_output_clamp #(
    .LEVEL_SHIFT(LEVEL_SHIFT)
  ) u_clamp (
    .sample(inport_data_i),
    .pixel (pixel)
  );

  // A push issued this cycle has not reached the buffer level yet
  assign space_ok = (ram_level_i + {31'd0, outport_push_o}) <= SPACE_LIMIT;

  assign accept          = (state == ST_WRITE) && inport_valid_i && !flush_i;
  assign inport_accept_o = accept;
  assign busy_o          = (state != ST_IDLE) || outport_push_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= ST_IDLE;
      cnt            <= 6'd0;
      outport_push_o <= 1'b0;
      outport_idx_o  <= 6'd0;
      outport_data_o <= 32'd0;
      block_done_o   <= 1'b0;
    end else if (flush_i) begin
      state          <= ST_IDLE;
      cnt            <= 6'd0;
      outport_push_o <= 1'b0;
      block_done_o   <= 1'b0;
    end else begin
      outport_push_o <= accept;
      block_done_o   <= accept && (cnt == LAST_SAMPLE);
      // cnt is {col,row}; the buffer wants {row,col}
      if (accept) begin
        outport_idx_o  <= {cnt[2:0], cnt[5:3]};
        outport_data_o <= {24'd0, pixel};
        cnt            <= cnt + 6'd1;
      end
      case (state)
        ST_IDLE: begin
          if (inport_valid_i) begin
            state <= ST_WAIT_SPACE;
          end
        end
        ST_WAIT_SPACE: begin
          if (space_ok) begin
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (accept && (cnt == LAST_SAMPLE)) begin
            state <= inport_valid_i ? ST_WAIT_SPACE : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_output_y_writer.sv
// Randomised and directed bench for jpeg_output_y_writer with a
// scoreboard model of the pixel/index stream.
module tb_jpeg_output_y_writer;

  localparam int RAM_DEPTH   = 512;
  localparam int LEVEL_SHIFT = 128;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        flush_i = 1'b0;
  logic        inport_valid_i = 1'b0;
  logic [15:0] inport_data_i = 16'd0;
  logic        inport_accept_o;
  logic [31:0] ram_level_i = 32'd0;
  logic        outport_push_o;
  logic [5:0]  outport_idx_o;
  logic [31:0] outport_data_o;
  logic        block_done_o;
  logic        busy_o;

  jpeg_output_y_writer #(
    .RAM_DEPTH  (RAM_DEPTH),
    .LEVEL_SHIFT(LEVEL_SHIFT)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .inport_valid_i (inport_valid_i),
    .inport_data_i  (inport_data_i),
    .inport_accept_o(inport_accept_o),
    .ram_level_i    (ram_level_i),
    .outport_push_o (outport_push_o),
    .outport_idx_o  (outport_idx_o),
    .outport_data_o (outport_data_o),
    .block_done_o   (block_done_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int assert_count = 0;
  int fail_count   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] model_pixel(input logic signed [15:0] v);
    int s;
    s = int'(v) + LEVEL_SHIFT;
    if (s < 0) return 8'd0;
    if (s > 255) return 8'd255;
    return 8'(s);
  endfunction

  // Sample n of a block arrives column-major: col = n/8, row = n%8
  function automatic logic [5:0] model_idx(input int n);
    return 6'((n % 8) * 8 + (n / 8));
  endfunction

  int          model_cnt = 0;
  bit          pend_valid = 0;
  bit          pend_last = 0;
  logic [5:0]  pend_idx = 6'd0;
  logic [31:0] pend_data = 32'd0;
  logic [5:0]  last_idx = 6'd0;
  logic [31:0] last_data = 32'd0;
  int          push_count = 0;
  logic [37:0] push_log[$];

  // Scoreboard: each observed handshake predicts the next cycle's push
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      model_cnt  = 0;
      pend_valid = 0;
      last_idx   = 6'd0;
      last_data  = 32'd0;
    end else begin
      checkOutput("push", 32'(outport_push_o), 32'(pend_valid));
      checkOutput("block_done", 32'(block_done_o), 32'(pend_valid && pend_last));
      if (pend_valid) begin
        checkOutput("idx", 32'(outport_idx_o), 32'(pend_idx));
        checkOutput("data", outport_data_o, pend_data);
        last_idx  = pend_idx;
        last_data = pend_data;
        push_count++;
        push_log.push_back({outport_idx_o, outport_data_o});
      end else begin
        checkOutput("idx_hold", 32'(outport_idx_o), 32'(last_idx));
        checkOutput("data_hold", outport_data_o, last_data);
      end
      if (outport_push_o) checkOutput("busy_on_push", 32'(busy_o), 32'd1);
      if (inport_accept_o) checkOutput("accept_needs_valid", 32'(inport_valid_i), 32'd1);
      if (flush_i) checkOutput("accept_in_flush", 32'(inport_accept_o), 32'd0);
      pend_valid = 0;
      if (flush_i) begin
        model_cnt = 0;
      end else if (inport_accept_o) begin
        pend_valid = 1;
        pend_idx   = model_idx(model_cnt);
        pend_data  = {24'd0, model_pixel(inport_data_i)};
        pend_last  = (model_cnt == 63);
        model_cnt  = (model_cnt + 1) % 64;
      end
    end
  end

  logic [15:0] stim_q[$];

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Streams stim_q with valid held high; counts refused cycles after the first accept
  task automatic applyStimulus(input int budget, output int gaps_after_first);
    int  cycles;
    bit  seen;
    bit  acc;
    cycles = 0;
    seen = 0;
    gaps_after_first = 0;
    while (stim_q.size() > 0 && cycles < budget) begin
      inport_valid_i = 1'b1;
      inport_data_i  = stim_q[0];
      @(negedge clk_i);
      acc = inport_accept_o;
      if (acc) seen = 1;
      else if (seen) gaps_after_first++;
      next_cycle();
      if (acc) void'(stim_q.pop_front());
      cycles++;
    end
    inport_valid_i = 1'b0;
    checkOutput("stream_complete", 32'(stim_q.size()), 32'd0);
    stim_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_push"}, 32'(outport_push_o), 32'd0);
    checkOutput({tag, "_idx"}, 32'(outport_idx_o), 32'd0);
    checkOutput({tag, "_data"}, outport_data_o, 32'd0);
    checkOutput({tag, "_done"}, 32'(block_done_o), 32'd0);
    checkOutput({tag, "_accept"}, 32'(inport_accept_o), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  task automatic run_basic_block(input string tag);
    int gaps;
    ram_level_i = 32'd0;
    for (int i = 0; i < 64; i++) stim_q.push_back(16'(i - 128));
    push_log.delete();
    push_count = 0;
    applyStimulus(300, gaps);
    next_cycle();
    checkOutput({tag, "_push_count"}, 32'(push_count), 32'd64);
    checkOutput({tag, "_gaps"}, 32'(gaps), 32'd0);
    checkOutput({tag, "_idx0"}, 32'(push_log[0][37:32]), 32'd0);
    checkOutput({tag, "_idx1"}, 32'(push_log[1][37:32]), 32'd8);
    checkOutput({tag, "_data1"}, push_log[1][31:0], 32'd1);
    checkOutput({tag, "_idx8"}, 32'(push_log[8][37:32]), 32'd1);
    checkOutput({tag, "_data8"}, push_log[8][31:0], 32'd8);
    checkOutput({tag, "_idx63"}, 32'(push_log[63][37:32]), 32'd63);
    checkOutput({tag, "_data63"}, push_log[63][31:0], 32'd63);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gaps;
    int clamp_in[6]         = '{-32768, -129, -128, 127, 128, 32767};
    logic [31:0] clamp_exp[6] = '{32'd0, 32'd0, 32'd0, 32'd255, 32'd255, 32'd255};

    #1 rst_ni = 1'b0;
    #2 check_all_zero("reset");
    inport_valid_i = 1'b1;
    #1 check_all_zero("reset_valid");
    next_cycle();
    next_cycle();
    inport_valid_i = 1'b0;
    rst_ni = 1'b1;

    $display("[TB] basic block");
    run_basic_block("basic");

    $display("[TB] clamp");
    for (int k = 0; k < 6; k++) stim_q.push_back(16'(clamp_in[k]));
    push_log.delete();
    applyStimulus(50, gaps);
    next_cycle();
    for (int k = 0; k < 6; k++) checkOutput($sformatf("clamp_%0d", k), push_log[k][31:0], clamp_exp[k]);
    flush_i = 1'b1;
    next_cycle();
    flush_i = 1'b0;

    $display("[TB] backpressure");
    ram_level_i    = 32'd449;
    inport_valid_i = 1'b1;
    inport_data_i  = 16'h0010;
    @(negedge clk_i);
    checkOutput("bp_idle_accept", 32'(inport_accept_o), 32'd0);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      checkOutput("bp_wait_accept", 32'(inport_accept_o), 32'd0);
      checkOutput("bp_wait_busy", 32'(busy_o), 32'd1);
      next_cycle();
    end
    ram_level_i = 32'd448;
    @(negedge clk_i);
    checkOutput("bp_space_same_cycle", 32'(inport_accept_o), 32'd0);
    next_cycle();
    @(negedge clk_i);
    checkOutput("bp_write_accept", 32'(inport_accept_o), 32'd1);
    next_cycle();
    inport_valid_i = 1'b0;
    flush_i = 1'b1;
    next_cycle();
    flush_i = 1'b0;

    $display("[TB] back-to-back blocks");
    ram_level_i = 32'd384;
    for (int i = 0; i < 128; i++) stim_q.push_back(16'($urandom));
    push_count = 0;
    applyStimulus(400, gaps);
    next_cycle();
    checkOutput("b2b_gaps", 32'(gaps), 32'd1);
    checkOutput("b2b_pushes", 32'(push_count), 32'd128);

    $display("[TB] flush mid-block");
    for (int i = 0; i < 20; i++) stim_q.push_back(16'($urandom));
    applyStimulus(100, gaps);
    inport_valid_i = 1'b1;
    inport_data_i  = 16'd5;
    flush_i        = 1'b1;
    @(negedge clk_i);
    checkOutput("flush_accept", 32'(inport_accept_o), 32'd0);
    next_cycle();
    flush_i        = 1'b0;
    inport_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("flush_no_push", 32'(outport_push_o), 32'd0);
    checkOutput("flush_idle", 32'(busy_o), 32'd0);
    next_cycle();
    run_basic_block("after_flush");

    $display("[TB] async reset mid-block");
    for (int i = 0; i < 30; i++) stim_q.push_back(16'(i - 100));
    applyStimulus(100, gaps);
    inport_valid_i = 1'b1;
    inport_data_i  = 16'd7;
    #2 rst_ni = 1'b0;
    #1 check_all_zero("async_reset");
    next_cycle();
    next_cycle();
    check_all_zero("reset_held");
    inport_valid_i = 1'b0;
    #2 rst_ni = 1'b1;
    next_cycle();
    run_basic_block("after_reset");

    $display("[TB] random traffic");
    for (int c = 0; c < 1500; c++) begin
      inport_valid_i = ($urandom_range(0, 3) != 0);
      inport_data_i  = 16'($urandom);
      ram_level_i    = 32'($urandom_range(380, 470));
      flush_i        = ($urandom_range(0, 99) == 0);
      next_cycle();
    end
    inport_valid_i = 1'b0;
    flush_i        = 1'b0;
    next_cycle();
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/jpeg_output_y_writer.md
JPEG_OUTPUT_Y_WRITER -- requirements
Module: jpeg_output_y_writer

Interface
REQ-001 SHALL have parameter RAM_DEPTH, default 512, meaning output Y buffer depth in 32-bit words (multiple of 64).
REQ-002 SHALL have parameter LEVEL_SHIFT, default 128, meaning the offset added to each IDCT sample before clamping.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port flush_i, input, 1 bit: synchronous abort of the current image.
REQ-006 SHALL have port inport_valid_i, input, 1 bit: an IDCT sample is present.
REQ-007 SHALL have port inport_data_i, input, 16 bits: a signed IDCT sample, in column-major order within the 8x8 block.
REQ-008 SHALL have port inport_accept_o, output, 1 bit: the sample is consumed this cycle.
REQ-009 SHALL have port ram_level_i, input, 32 bits: the Y buffer occupancy, taken from the buffer's level output.
REQ-010 SHALL have port outport_push_o, output, 1 bit: write strobe to the Y buffer.
REQ-011 SHALL have port outport_idx_o, output, 6 bits: raster index within the block, {row[2:0], col[2:0]}.
REQ-012 SHALL have port outport_data_o, output, 32 bits: the pixel, zero-extended from 8 bits.
REQ-013 SHALL have port block_done_o, output, 1 bit: one-cycle pulse when the 64th push of a block is issued.
REQ-014 SHALL have port busy_o, output, 1 bit: high whenever the FSM is not IDLE or a push is pending.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_SPACE and WRITE.
REQ-016 SHALL move IDLE->WAIT_SPACE when inport_valid_i=1.
REQ-017 SHALL move WAIT_SPACE->WRITE when space_ok, where space_ok = (ram_level_i + outport_push_o) <= RAM_DEPTH-64, with the comparison evaluated in 32 bits.
REQ-018 SHALL hold inport_accept_o = inport_valid_i only in WRITE, and 0 in every other state.
REQ-019 SHALL keep a 6-bit sample counter cnt, incremented on each accepted sample, with cnt[5:3]=col and cnt[2:0]=row.
REQ-020 SHALL move WRITE->WAIT_SPACE when sample 63 is accepted and inport_valid_i is still asserted, and WRITE->IDLE otherwise; cnt wraps to 0 in both cases.
REQ-021 SHALL, for each accepted sample, register on the next cycle outport_push_o=1, outport_idx_o={cnt[2:0],cnt[5:3]} and outport_data_o=clamp(inport_data_i+LEVEL_SHIFT, 0, 255), giving a latency of exactly 1 cycle.
REQ-022 SHALL compute the level-shift sum in 17-bit signed arithmetic, so that no intermediate overflow occurs.
REQ-023 SHALL issue exactly 64 pushes per block, with block index advancement left to the buffer's write pointer.
REQ-024 SHALL hold outport_push_o=0 on cycles where no sample was accepted on the previous cycle; outport_data_o and outport_idx_o hold their last values.
REQ-025 SHALL assert block_done_o in the same cycle as the push for cnt=63.
REQ-026 SHALL, on flush_i=1, force next state IDLE, cnt=0, outport_push_o=0 and block_done_o=0, and deassert inport_accept_o in that cycle; flush takes priority over all other events.
REQ-027 SHALL never accept a sample in WAIT_SPACE, even when space_ok is true in the same cycle; acceptance begins the following cycle.

Reset
REQ-028 SHALL, while rst_ni=0, asynchronously clear state to IDLE, cnt to 0, outport_push_o to 0, outport_idx_o to 0, outport_data_o to 0 and block_done_o to 0.
REQ-029 SHALL drive busy_o=0 and inport_accept_o=0 during reset.
REQ-030 SHALL discard any partial block when reset is asserted mid-block; after release, the next sample is treated as sample 0.

Structure
REQ-031 SHALL place the FSM state encoding, block size 64 and pixel clamp bounds 0/255 in the shared jpeg package.
REQ-032 SHALL implement the clamp/level-shift as one sub-module, jpeg_output_clamp (combinational, 16-bit signed in, 8-bit out); all other logic SHALL be flat.

Verification
REQ-033 SHALL be verified for basic block: ram_level_i=0, samples 0..63 with value v=i-128 in column-major order -> 64 pushes, cycle 1 after accept, outport_idx_o sequence 0,8,16,...,56,1,9,...; data=i; block_done_o on the 64th push.
REQ-034 SHALL be verified for clamp: inputs -32768, -129, -128, 127, 128, 32767 -> data 0, 0, 0, 255, 255, 255.
REQ-035 SHALL be verified for backpressure: ram_level_i=449 with valid held -> stays in WAIT_SPACE, accept=0; drop to 448 -> WRITE entered the next cycle, then accept.
REQ-036 SHALL be verified for back-to-back blocks: 128 continuous valid samples, ram_level_i=384 tied -> exactly one accept-gap cycle for WAIT_SPACE between blocks, and 128 pushes.
REQ-037 SHALL be verified for flush mid-block: flush_i after 20 accepts -> no push on the next cycle, state IDLE; the next block starts with outport_idx_o=0.
REQ-038 SHALL be verified for async reset mid-block: rst_ni low after 30 accepts -> all outputs 0 immediately without a clock edge; on release, behaviour matches REQ-033.
